// File: rtl/int_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : int_sequencer
//  Description : Interrupt sequencer between the source flags and the CPU core.
//                Masks the five pending sources with IE, resolves two-level
//                priority (IP) with fixed polling order inside each level,
//                tracks nested in-service levels, presents a vector to the
//                core over a req/ack handshake, pulses flag-clear lines for
//                hardware-cleared sources on acknowledge and retires levels
//                on RETI.
//  Ports       : clk       in   1  system clock
//                rst_n     in   1  asynchronous active-low reset
//                src_pend  in   5  pending flags [0]INT0 [1]T0 [2]INT1 [3]T1 [4]UART
//                ie        in   8  [7] global enable, [4:0] per-source enables
//                ip        in   5  1 = high priority, same order as src_pend
//                blk       in   1  core no-interrupt window
//                int_ack   in   1  core accepts the presented vector
//                reti      in   1  one-cycle pulse, RETI executed
//                int_req   out  1  interrupt request to core
//                int_vec   out 16  vector address, valid while int_req=1
//                src_clr   out  5  one-hot one-cycle flag-clear pulse
//                in_svc    out  2  [1] high level active, [0] low level active
//  Revision    : 1.0  initial release
// ============================================================================
module int_sequencer #(
    parameter logic [15:0] VEC_BASE   = 16'h0003,
    parameter int unsigned VEC_STRIDE = 8,
    parameter logic [4:0]  CLR_MASK   = 5'b01111
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  src_pend,
    input  logic [7:0]  ie,
    input  logic [4:0]  ip,
    input  logic        blk,
    input  logic        int_ack,
    input  logic        reti,
    output logic        int_req,
    output logic [15:0] int_vec,
    output logic [4:0]  src_clr,
    output logic [1:0]  in_svc
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    state_t      r_state;
    logic [4:0]  r_pend_q;
    logic [2:0]  r_idx;
    logic        r_lvl;

    logic [4:0]  w_elig;
    logic [4:0]  w_hi_elig;
    logic [4:0]  w_cand;
    logic        w_any;
    logic        w_win_hi;
    logic [2:0]  w_win_idx;
    logic        w_allowed;
    logic [15:0] w_vec;
    logic [1:0]  w_svc_reti;
    logic        w_unused;

    // IE bits 6:5 are not interrupt enables
    assign w_unused  = &{1'b0, ie[6:5]};

    assign w_elig    = r_pend_q & ie[4:0] & {5{ie[7]}};
    assign w_hi_elig = w_elig & ip;
    assign w_any     = |w_elig;
    assign w_win_hi  = |w_hi_elig;
    assign w_cand    = w_win_hi ? w_hi_elig : w_elig;

    // Lowest index wins within the selected level: scan downwards so the
    // last assignment is the lowest set bit.
    always_comb begin
        w_win_idx = 3'd0;
        for (int i = 4; i >= 0; i--) begin
            if (w_cand[i]) begin
                w_win_idx = 3'(i);
            end
        end
    end

    // A request at the active high level blocks everything; an active low
    // level only lets high-priority sources through.
    assign w_allowed = w_any && !blk && !in_svc[1] && (w_win_hi || !in_svc[0]);

    assign w_vec     = VEC_BASE + 16'(w_win_idx) * 16'(VEC_STRIDE);

    // In-service state after a RETI in this cycle; an acknowledge in the
    // same cycle then sets its level on top of this.
    assign w_svc_reti = !reti     ? in_svc :
                        in_svc[1] ? {1'b0, in_svc[0]} : 2'b00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_pend_q <= 5'd0;
            r_idx    <= 3'd0;
            r_lvl    <= 1'b0;
            int_req  <= 1'b0;
            int_vec  <= 16'd0;
            src_clr  <= 5'd0;
            in_svc   <= 2'b00;
        end else begin
            r_pend_q <= src_pend;
            in_svc   <= w_svc_reti;
            case (r_state)
                ST_IDLE: begin
                    if (w_allowed) begin
                        r_state <= ST_REQ;
                        int_req <= 1'b1;
                        int_vec <= w_vec;
                        r_idx   <= w_win_idx;
                        r_lvl   <= w_win_hi;
                    end
                end
                ST_REQ: begin
                    // Vector, index and level stay frozen until ack or abort
                    if (int_ack) begin
                        r_state <= ST_ACK;
                        int_req <= 1'b0;
                        in_svc  <= w_svc_reti | (r_lvl ? 2'b10 : 2'b01);
                        src_clr <= CLR_MASK & (5'b00001 << r_idx);
                    end else if (!ie[7]) begin
                        r_state <= ST_IDLE;
                        int_req <= 1'b0;
                    end
                end
                ST_ACK: begin
                    src_clr <= 5'd0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    int_req <= 1'b0;
                    src_clr <= 5'd0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_int_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_int_sequencer
//  Description : Self-checking bench for int_sequencer: directed scenarios
//                followed by randomized traffic compared against a
//                transaction-level reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_int_sequencer;

    logic        clk;
    logic        rst_n;
    logic [4:0]  src_pend;
    logic [7:0]  ie;
    logic [4:0]  ip;
    logic        blk;
    logic        int_ack;
    logic        reti;
    logic        int_req;
    logic [15:0] int_vec;
    logic [4:0]  src_clr;
    logic [1:0]  in_svc;

    int checks = 0;
    int passes = 0;

    localparam logic [4:0] c_CLR_MASK = 5'b01111;

    int_sequencer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .src_pend (src_pend),
        .ie       (ie),
        .ip       (ip),
        .blk      (blk),
        .int_ack  (int_ack),
        .reti     (reti),
        .int_req  (int_req),
        .int_vec  (int_vec),
        .src_clr  (src_clr),
        .in_svc   (in_svc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // advance one edge, land 1 time unit after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; src_pend = 5'd0; ie = 8'd0; ip = 5'd0;
        blk = 1'b0; int_ack = 1'b0; reti = 1'b0;
        step(); step();
        rst_n = 1'b1;
    endtask

    task automatic wait_req(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < max_cyc; n++) begin
            step();
            if (int_req === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bit ok;
        rst_n = 1'b0; src_pend = 5'h1F; ie = 8'hFF; ip = 5'd0;
        blk = 1'b0; int_ack = 1'b0; reti = 1'b0;
        step(); step();
        checks++; if (int_req !== 1'b0) $display("FAIL reset_req got=%b exp=0", int_req); else passes++;
        checks++; if (int_vec !== 16'h0) $display("FAIL reset_vec got=%h exp=0000", int_vec); else passes++;
        checks++; if (src_clr !== 5'd0) $display("FAIL reset_clr got=%b exp=00000", src_clr); else passes++;
        checks++; if (in_svc !== 2'b00) $display("FAIL reset_svc got=%b exp=00", in_svc); else passes++;
        rst_n = 1'b1;
        wait_req(4, ok);
        checks++; if (!ok) $display("FAIL reset_release no request got=0 exp=1"); else passes++;
    endtask

    task automatic test_basic();
        do_reset();
        ie = 8'h81; src_pend = 5'b00001;
        step();
        checks++; if (int_req !== 1'b0) $display("FAIL basic_latency_early got=%b exp=0", int_req); else passes++;
        step();
        checks++; if (int_req !== 1'b1) $display("FAIL basic_req got=%b exp=1", int_req); else passes++;
        checks++; if (int_vec !== 16'h0003) $display("FAIL basic_vec got=%h exp=0003", int_vec); else passes++;
        src_pend = 5'd0; int_ack = 1'b1;
        step();
        int_ack = 1'b0;
        checks++; if (int_req !== 1'b0) $display("FAIL basic_req_drop got=%b exp=0", int_req); else passes++;
        checks++; if (src_clr !== 5'b00001) $display("FAIL basic_clr got=%b exp=00001", src_clr); else passes++;
        checks++; if (in_svc !== 2'b01) $display("FAIL basic_svc got=%b exp=01", in_svc); else passes++;
        step();
        checks++; if (src_clr !== 5'd0) $display("FAIL basic_clr_pulse got=%b exp=00000", src_clr); else passes++;
        reti = 1'b1; step(); reti = 1'b0;
        checks++; if (in_svc !== 2'b00) $display("FAIL basic_reti got=%b exp=00", in_svc); else passes++;
    endtask

    task automatic test_priority();
        bit ok;
        do_reset();
        ie = 8'h9F; ip = 5'b01000; src_pend = 5'b01011;
        wait_req(4, ok);
        checks++; if (!ok) $display("FAIL prio_req timeout got=0 exp=1"); else passes++;
        checks++; if (int_vec !== 16'h001B) $display("FAIL prio_vec_hi got=%h exp=001B", int_vec); else passes++;
        int_ack = 1'b1; step(); int_ack = 1'b0;
        src_pend = 5'b00011;
        checks++; if (in_svc !== 2'b10) $display("FAIL prio_svc_hi got=%b exp=10", in_svc); else passes++;
        checks++; if (src_clr !== 5'b01000) $display("FAIL prio_clr got=%b exp=01000", src_clr); else passes++;
        step(); step();
        checks++; if (int_req !== 1'b0) $display("FAIL prio_hi_blocks got=%b exp=0", int_req); else passes++;
        reti = 1'b1; step(); reti = 1'b0;
        checks++; if (in_svc !== 2'b00) $display("FAIL prio_reti got=%b exp=00", in_svc); else passes++;
        wait_req(4, ok);
        checks++; if (!ok) $display("FAIL prio_req2 timeout got=0 exp=1"); else passes++;
        checks++; if (int_vec !== 16'h0003) $display("FAIL prio_vec_lo got=%h exp=0003", int_vec); else passes++;
    endtask

    task automatic test_nesting();
        bit ok;
        bit seen;
        do_reset();
        ie = 8'h9F; ip = 5'b01000; src_pend = 5'b00001;
        wait_req(4, ok);
        checks++; if (!ok || int_vec !== 16'h0003) $display("FAIL nest_int0 got=%b/%h exp=1/0003", ok, int_vec); else passes++;
        int_ack = 1'b1; src_pend = 5'd0; step(); int_ack = 1'b0;
        checks++; if (in_svc !== 2'b01) $display("FAIL nest_svc_lo got=%b exp=01", in_svc); else passes++;
        src_pend = 5'b01010;
        wait_req(6, ok);
        checks++; if (!ok || int_vec !== 16'h001B) $display("FAIL nest_preempt got=%b/%h exp=1/001B", ok, int_vec); else passes++;
        int_ack = 1'b1; src_pend = 5'b00010; step(); int_ack = 1'b0;
        checks++; if (in_svc !== 2'b11) $display("FAIL nest_svc_both got=%b exp=11", in_svc); else passes++;
        seen = 1'b0;
        repeat (4) begin step(); if (int_req !== 1'b0) seen = 1'b1; end
        checks++; if (seen) $display("FAIL nest_block_hi got=1 exp=0"); else passes++;
        reti = 1'b1; step(); reti = 1'b0;
        checks++; if (in_svc !== 2'b01) $display("FAIL nest_reti1 got=%b exp=01", in_svc); else passes++;
        seen = 1'b0;
        repeat (4) begin step(); if (int_req !== 1'b0) seen = 1'b1; end
        checks++; if (seen) $display("FAIL nest_block_lo got=1 exp=0"); else passes++;
        reti = 1'b1; step(); reti = 1'b0;
        checks++; if (in_svc !== 2'b00) $display("FAIL nest_reti2 got=%b exp=00", in_svc); else passes++;
        wait_req(4, ok);
        checks++; if (!ok || int_vec !== 16'h000B) $display("FAIL nest_t0 got=%b/%h exp=1/000B", ok, int_vec); else passes++;
    endtask

    task automatic test_uart_blk();
        bit ok;
        bit seen;
        do_reset();
        ie = 8'h90; src_pend = 5'b10000;
        wait_req(4, ok);
        checks++; if (!ok || int_vec !== 16'h0023) $display("FAIL uart_vec got=%b/%h exp=1/0023", ok, int_vec); else passes++;
        int_ack = 1'b1; step(); int_ack = 1'b0;
        checks++; if (src_clr !== 5'd0) $display("FAIL uart_noclr got=%b exp=00000", src_clr); else passes++;
        checks++; if (in_svc !== 2'b01) $display("FAIL uart_svc got=%b exp=01", in_svc); else passes++;
        blk = 1'b1; reti = 1'b1; step(); reti = 1'b0;
        seen = 1'b0;
        repeat (5) begin step(); if (int_req !== 1'b0) seen = 1'b1; end
        checks++; if (seen) $display("FAIL uart_blk got=1 exp=0"); else passes++;
        blk = 1'b0;
        wait_req(4, ok);
        checks++; if (!ok || int_vec !== 16'h0023) $display("FAIL uart_unblk got=%b/%h exp=1/0023", ok, int_vec); else passes++;
        blk = 1'b1; step(); step();
        checks++; if (int_req !== 1'b1) $display("FAIL uart_blk_holds got=%b exp=1", int_req); else passes++;
        blk = 1'b0;
    endtask

    task automatic test_abort_reset();
        bit ok;
        do_reset();
        ie = 8'h81; src_pend = 5'b00001;
        wait_req(4, ok);
        checks++; if (!ok) $display("FAIL abort_req timeout got=0 exp=1"); else passes++;
        ie = 8'h01; step();
        checks++; if ({int_req, src_clr, in_svc} !== 8'd0) $display("FAIL abort_drop got=%b exp=00000000", {int_req, src_clr, in_svc}); else passes++;
        ie = 8'h81;
        wait_req(4, ok);
        checks++; if (!ok) $display("FAIL abort_rereq timeout got=0 exp=1"); else passes++;
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({int_req, int_vec, src_clr, in_svc} !== 24'd0) $display("FAIL async_reset got=%h exp=000000", {int_req, int_vec, src_clr, in_svc}); else passes++;
        step();
        rst_n = 1'b1; src_pend = 5'd0; ie = 8'h81;
        reti = 1'b1; int_ack = 1'b1; step(); reti = 1'b0; int_ack = 1'b0;
        checks++; if ({src_clr, in_svc} !== 7'd0) $display("FAIL idle_reti_ack got=%b exp=0000000", {src_clr, in_svc}); else passes++;
    endtask

    // Reference model: the in-service levels are a stack of nested handlers,
    // a pending request is a (source, level) transaction awaiting acceptance.
    task automatic test_random();
        logic [4:0]  flags;
        logic [4:0]  m_pq;
        logic [4:0]  m_clr;
        logic [4:0]  elig;
        logic [15:0] m_vec;
        logic [1:0]  m_svc;
        bit          m_req, m_ackph, m_lvl, old_hi, old_lo, wl, uart_sw;
        int          m_src, w;
        int          stack[$];

        do_reset();
        flags = 5'd0; m_pq = 5'd0; m_clr = 5'd0; m_vec = 16'd0;
        m_req = 1'b0; m_ackph = 1'b0; m_lvl = 1'b0; m_src = 0;
        ie = 8'h9F; ip = 5'($urandom);

        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < 5; i++) if ($urandom_range(15) == 0) flags[i] = 1'b1;
            src_pend = flags;
            if ($urandom_range(40) == 0) ie = {($urandom_range(5) != 0), 2'b00, 5'($urandom)};
            if ($urandom_range(40) == 0) ip = 5'($urandom);
            blk     = ($urandom_range(7) == 0);
            int_ack = m_req ? ($urandom_range(2) == 0) : ($urandom_range(9) == 0);
            reti    = (stack.size() > 0) ? ($urandom_range(11) == 0) : ($urandom_range(39) == 0);

            // predict the outcome of the coming edge
            old_hi = 1'b0; old_lo = 1'b0;
            foreach (stack[k]) begin
                if (stack[k] == 1) old_hi = 1'b1; else old_lo = 1'b1;
            end
            elig = m_pq & ie[4:0] & {5{ie[7]}};
            w = -1; wl = 1'b0;
            for (int lv = 1; lv >= 0; lv--)
                for (int i = 0; i < 5; i++)
                    if (w < 0 && elig[i] && ip[i] == lv[0]) begin w = i; wl = lv[0]; end
            if (reti && stack.size() > 0) void'(stack.pop_back());
            m_clr = 5'd0; uart_sw = 1'b0;
            if (m_req) begin
                if (int_ack) begin
                    m_req = 1'b0; m_ackph = 1'b1;
                    stack.push_back(int'(m_lvl));
                    m_clr = c_CLR_MASK & (5'b00001 << m_src);
                    uart_sw = (m_src == 4);
                end else if (!ie[7]) begin
                    m_req = 1'b0;
                end
            end else if (m_ackph) begin
                m_ackph = 1'b0;
            end else if (w >= 0 && !blk && !old_hi && (wl || !old_lo)) begin
                m_req = 1'b1; m_src = w; m_lvl = wl;
                m_vec = 16'h0003 + 16'(w * 8);
            end
            m_pq = flags;
            m_svc = 2'b00;
            foreach (stack[k]) begin
                if (stack[k] == 1) m_svc[1] = 1'b1; else m_svc[0] = 1'b1;
            end

            step();
            checks++; if (int_req !== m_req) $display("FAIL rnd_req cyc=%0d got=%b exp=%b", cyc, int_req, m_req); else passes++;
            if (m_req) begin
                checks++; if (int_vec !== m_vec) $display("FAIL rnd_vec cyc=%0d got=%h exp=%h", cyc, int_vec, m_vec); else passes++;
            end
            checks++; if (src_clr !== m_clr) $display("FAIL rnd_clr cyc=%0d got=%b exp=%b", cyc, src_clr, m_clr); else passes++;
            checks++; if (in_svc !== m_svc) $display("FAIL rnd_svc cyc=%0d got=%b exp=%b", cyc, in_svc, m_svc); else passes++;

            // flag hardware reacts to the clear pulse; UART is cleared by software
            flags = flags & ~m_clr;
            if (uart_sw) flags[4] = 1'b0;
        end
        int_ack = 1'b0; reti = 1'b0; blk = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_priority();
        test_nesting();
        test_uart_blk();
        test_abort_reset();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
